// File: rtl/sync_bits_data_pkg.sv
// Shared constants for the sync_bits_data CDC block.
// Provides the legal synchronizer depth range and a helper to check it.
package sync_bits_data_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    function automatic bit stages_in_range(input int unsigned n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Per-bit multi-flop synchronizer with a synchronous active-high clear.
// Every bit is independent; no coherence is implied across the vector.
module cdc_sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Keep these flops adjacent and untouched by retiming or merging.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // NOTE: non-blocking assignment so every stage samples the previous stage's old value.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/sync_bits_data.sv
// Destination-side CDC: independent flags through synchronizers, plus a
// toggle-qualified multi-bit bus captured coherently into out_clk.
module sync_bits_data
    import sync_bits_data_pkg::*;
#(
    parameter int unsigned NUM_OF_BITS = 1,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ASYNC_CLK   = 1'b1
) (
    input  logic                   out_clk,
    input  logic                   out_reset,
    input  logic [NUM_OF_BITS-1:0] in_bits,
    output logic [NUM_OF_BITS-1:0] out_bits,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_toggle,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid
);

    if (!stages_in_range(SYNC_STAGES)) begin : g_bad_stages
        $error("sync_bits_data: SYNC_STAGES must be within 2..4");
    end

    if (ASYNC_CLK) begin : g_async
        logic                  w_tog_s;
        logic                  w_change;
        logic                  r_tog_r;
        logic [DATA_WIDTH-1:0] r_out_data;
        logic                  r_out_valid;

        cdc_sync_chain #(
            .WIDTH  (NUM_OF_BITS),
            .STAGES (SYNC_STAGES)
        ) u_bits_sync (
            .i_clk (out_clk),
            .i_clr (out_reset),
            .i_d   (in_bits),
            .o_q   (out_bits)
        );

        cdc_sync_chain #(
            .WIDTH  (1),
            .STAGES (SYNC_STAGES)
        ) u_toggle_sync (
            .i_clk (out_clk),
            .i_clr (out_reset),
            .i_d   (in_toggle),
            .o_q   (w_tog_s)
        );

        // in_data is sampled directly: the source holds it stable around the toggle.
        assign w_change = w_tog_s ^ r_tog_r;

        always_ff @(posedge out_clk) begin
            if (out_reset) begin
                r_tog_r     <= 1'b0;
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_tog_r     <= w_tog_s;
                r_out_valid <= w_change;
                if (w_change) begin
                    r_out_data <= in_data;
                end
            end
        end

        assign out_data  = r_out_data;
        assign out_valid = r_out_valid;
    end else begin : g_bypass
        logic r_tog_d;

        always_ff @(posedge out_clk) begin
            if (out_reset) begin
                r_tog_d <= 1'b0;
            end else begin
                r_tog_d <= in_toggle;
            end
        end

        // Same-clock source: no synchronization, only edge-detect the toggle.
        assign out_bits  = in_bits;
        assign out_data  = in_data;
        assign out_valid = in_toggle ^ r_tog_d;
    end

endmodule

// File: tb/tb_sync_bits_data.sv
// Self-checking bench for sync_bits_data: a synchronizing instance and a
// bypass instance, directed scenarios followed by randomized traffic.
module tb_sync_bits_data;

    localparam int NB = 4;
    localparam int DW = 16;
    localparam int S  = 2;

    logic          clk;
    logic          rst;
    logic [NB-1:0] in_bits;
    logic [DW-1:0] in_data;
    logic          in_toggle;

    logic [NB-1:0] a_bits;
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic [NB-1:0] b_bits;
    logic [DW-1:0] b_data;
    logic          b_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    sync_bits_data #(
        .NUM_OF_BITS (NB),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (S),
        .ASYNC_CLK   (1'b1)
    ) u_async (
        .out_clk   (clk),
        .out_reset (rst),
        .in_bits   (in_bits),
        .out_bits  (a_bits),
        .in_data   (in_data),
        .in_toggle (in_toggle),
        .out_data  (a_data),
        .out_valid (a_valid)
    );

    sync_bits_data #(
        .NUM_OF_BITS (NB),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (S),
        .ASYNC_CLK   (1'b0)
    ) u_bypass (
        .out_clk   (clk),
        .out_reset (rst),
        .in_bits   (in_bits),
        .out_bits  (b_bits),
        .in_data   (in_data),
        .in_toggle (in_toggle),
        .out_data  (b_data),
        .out_valid (b_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: histories of input samples, index k = sampled k edges ago.
    // A reset edge wipes the history, since every flop it feeds is cleared.
    logic [NB-1:0] m_bits_h [0:S-1];
    logic          m_tog_h  [0:S];
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_byp_tog;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < S; i++)  m_bits_h[i] <= '0;
            for (int i = 0; i <= S; i++) m_tog_h[i]  <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_byp_tog <= 1'b0;
        end else begin
            m_bits_h[0] <= in_bits;
            for (int i = 1; i < S; i++)  m_bits_h[i] <= m_bits_h[i-1];
            m_tog_h[0] <= in_toggle;
            for (int i = 1; i <= S; i++) m_tog_h[i]  <= m_tog_h[i-1];
            // A toggle change seen S+1 edges after it was sampled raises valid.
            m_valid <= m_tog_h[S-1] ^ m_tog_h[S];
            if (m_tog_h[S-1] ^ m_tog_h[S]) m_data <= in_data;
            m_byp_tog <= in_toggle;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("async_bits",   32'(a_bits),  32'(m_bits_h[S-1]));
        check("async_data",   32'(a_data),  32'(m_data));
        check("async_valid",  32'(a_valid), 32'(m_valid));
        check("bypass_valid", 32'(b_valid), 32'(in_toggle ^ m_byp_tog));
        if (a_valid === 1'b1) pulses++;
    endtask

    task automatic check_bypass();
        #1;
        check("bypass_bits",  32'(b_bits),  32'(in_bits));
        check("bypass_data",  32'(b_data),  32'(in_data));
        check("bypass_valid", 32'(b_valid), 32'(in_toggle ^ m_byp_tog));
    endtask

    initial begin
        int gap;
        int next_gap;

        // Reset held with all inputs high: outputs stay cleared.
        rst       = 1'b1;
        in_bits   = '1;
        in_toggle = 1'b1;
        in_data   = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_bits",  32'(a_bits),  32'h0);
            check("rst_data",  32'(a_data),  32'h0);
            check("rst_valid", 32'(a_valid), 32'h0);
        end

        // Release with in_toggle=1: one capture of the current word.
        rst     = 1'b0;
        in_bits = '0;
        pulses  = 0;
        for (int i = 0; i < 5; i++) step();
        check("release_pulses", 32'(pulses), 32'd1);
        check("release_data",   32'(a_data), 32'hFFFF);

        // Bit latency: visible on the second edge after the change.
        in_bits = 4'b0001;
        step();
        check("bit_lat_early", 32'(a_bits), 32'h0);
        step();
        check("bit_lat_on",    32'(a_bits), 32'h1);

        // Single word capture, pulse three edges after the toggle.
        in_data   = 16'hA5C3;
        in_toggle = ~in_toggle;
        step();
        check("cap_wait1", 32'(a_valid), 32'h0);
        step();
        check("cap_wait2", 32'(a_valid), 32'h0);
        step();
        check("cap_pulse", 32'(a_valid), 32'h1);
        check("cap_data",  32'(a_data),  32'hA5C3);
        step();
        check("cap_drop",  32'(a_valid), 32'h0);
        check("cap_hold",  32'(a_data),  32'hA5C3);

        // Two words spaced six cycles apart.
        pulses    = 0;
        in_data   = 16'h0001;
        in_toggle = ~in_toggle;
        for (int i = 0; i < 6; i++) step();
        in_data   = 16'h0002;
        in_toggle = ~in_toggle;
        for (int i = 0; i < 6; i++) step();
        check("two_pulses", 32'(pulses), 32'd2);
        check("two_data",   32'(a_data), 32'h0002);

        // Reset one cycle after a toggle: transfer is discarded.
        pulses    = 0;
        in_data   = 16'hBEEF;
        in_toggle = ~in_toggle;
        step();
        rst       = 1'b1;
        in_toggle = 1'b0;
        step();
        check("midrst_valid", 32'(a_valid), 32'h0);
        check("midrst_data",  32'(a_data),  32'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("midrst_pulses", 32'(pulses), 32'd0);
        check("midrst_after",  32'(a_data), 32'h0);

        // Bypass instance: combinational paths and a one-cycle toggle pulse.
        in_bits = 4'b0001;
        in_data = 16'h1234;
        check_bypass();
        check("byp_bits_now", 32'(b_bits), 32'h1);
        check("byp_data_now", 32'(b_data), 32'h1234);
        in_toggle = ~in_toggle;
        #1;
        check("byp_pulse", 32'(b_valid), 32'h1);
        step();
        check("byp_pulse_end", 32'(b_valid), 32'h0);

        // Randomized traffic respecting the minimum toggle spacing.
        gap      = 0;
        next_gap = int'($urandom_range(S + 2, S + 6));
        for (int c = 0; c < 400; c++) begin
            step();
            in_bits = NB'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst       = 1'b1;
                in_toggle = 1'b0;
                gap       = 0;
            end else begin
                rst = 1'b0;
                gap++;
                if (gap >= next_gap) begin
                    in_data   = DW'($urandom);
                    in_toggle = ~in_toggle;
                    gap       = 0;
                    next_gap  = int'($urandom_range(S + 2, S + 6));
                end
            end
            check_bypass();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
